// File: rtl/ax25_pkg.sv
// ax25_pkg: shared constants and types for the AX.25 HDLC transmitter.
//   Register addresses, transmit FSM states, the HDLC flag byte,
//   status-word bit positions and the FIFO entry layout.
package ax25_pkg;

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_LAST = 3'd1;
  localparam logic [2:0] A_CTRL = 3'd2;
  localparam logic [2:0] A_STAT = 3'd3;

  localparam logic [7:0] FLAG = 8'h7E;

  localparam int unsigned ST_BUSY  = 7;
  localparam int unsigned ST_OVF   = 6;
  localparam int unsigned ST_UDR   = 5;
  localparam int unsigned ST_LVL_W = 5;

  localparam int unsigned ENT_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    CLOSE,
    ABORT
  } tx_state_t;

  // One FIFO entry: payload byte plus end-of-frame marker
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_ent_t;

endpackage

// File: rtl/hdlc_fifo.sv
// hdlc_fifo: synchronous show-ahead FIFO with occupancy count.
//   clk, rst     : clock, synchronous active-high reset
//   i_push       : write i_wdata (ignored when full)
//   i_pop        : drop head entry (ignored when empty)
//   i_flush      : empty the FIFO
//   o_head_c     : current head entry (combinational)
//   o_empty_c    : FIFO empty (combinational)
//   o_full_c     : FIFO full (combinational)
//   o_level      : number of stored entries
module hdlc_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_head_c,
  output logic                   o_empty_c,
  output logic                   o_full_c,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [LW-1:0]    r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_empty_c = (r_cnt == '0);
  assign o_full_c  = (r_cnt == LW'(DEPTH));
  assign w_wr      = i_push & ~o_full_c;
  assign w_rd      = i_pop & ~o_empty_c;
  assign o_head_c  = r_mem[r_rp];
  assign o_level   = r_cnt;

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

  // Pointers and count; simultaneous push and pop both take effect
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + LW'(w_wr) - LW'(w_rd);
    end
  end

endmodule

// File: rtl/ax25_hdlc_tx.sv
// ax25_hdlc_tx: AX.25 HDLC frame transmitter with byte FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   iocs/iowr/iord  : chip select, write and read strobes
//   ioaddr, din     : register address, write data
//   dout            : registered read data (status at address 3)
//   bitce           : one-clk enable per serial bit
//   txd, txen       : serial line data, transmitter keyed
// Build option: define NRZI_EN to NRZI-code txd (0 toggles, 1 holds).
module ax25_hdlc_tx
  import ax25_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PRE_DEF    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iocs,
  input  logic [2:0]  ioaddr,
  input  logic [15:0] din,
  input  logic        iowr,
  input  logic        iord,
  output logic [15:0] dout,
  input  logic        bitce,
  output logic        txd,
  output logic        txen
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t r_state, w_state_nxt;
  logic [7:0] r_sh, w_sh_nxt;
  logic [3:0] r_bcnt, w_bcnt_nxt;
  logic [3:0] r_pcnt, w_pcnt_nxt;
  logic [2:0] r_ones, w_ones_nxt;
  logic       r_last, w_last_nxt;
  logic       r_txd, r_txen;
  logic [15:0] r_dout;
  logic       r_ovf, r_udr, r_start_pend;
  logic [3:0] r_pre;

  logic       w_bit, w_txen_nxt, w_pop, w_flush, w_udr_set, w_go, w_bnd;
  logic [2:0] w_ones_add;
  logic       w_push, w_ctrl, w_rd_stat, w_busy;
  fifo_ent_t  w_wr_ent, w_head;
  logic [ENT_W-1:0] w_head_raw;
  logic       w_empty_c, w_full_c;
  logic [LW-1:0] w_level;
  logic [15:0] w_status;
  logic       w_unused;

  assign w_push    = iocs & iowr & ((ioaddr == A_DATA) | (ioaddr == A_LAST));
  assign w_ctrl    = iocs & iowr & (ioaddr == A_CTRL);
  assign w_rd_stat = iocs & iord & (ioaddr == A_STAT);
  assign w_wr_ent  = '{last: (ioaddr == A_LAST), data: din[7:0]};
  assign w_head    = fifo_ent_t'(w_head_raw);
  assign w_busy    = (r_state != IDLE);
  assign w_unused  = ^{din[15:8], din[3:2]};

  always_comb begin
    w_status = '0;
    w_status[ST_BUSY] = w_busy;
    w_status[ST_OVF]  = r_ovf;
    w_status[ST_UDR]  = r_udr;
    w_status[ST_LVL_W-1:0] = ST_LVL_W'(w_level);
  end

  hdlc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wdata   (w_wr_ent),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .o_head_c  (w_head_raw),
    .o_empty_c (w_empty_c),
    .o_full_c  (w_full_c),
    .o_level   (w_level)
  );

  // Next-state and bit selection; only evaluated on bit-enable clks
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_bcnt_nxt  = r_bcnt;
    w_pcnt_nxt  = r_pcnt;
    w_ones_nxt  = r_ones;
    w_last_nxt  = r_last;
    w_bit       = 1'b1;
    w_txen_nxt  = r_txen;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_udr_set   = 1'b0;
    w_go        = 1'b0;
    w_bnd       = 1'b0;
    w_ones_add  = '0;
    if (bitce) begin
      unique case (r_state)
        IDLE: begin
          w_txen_nxt = 1'b0;
          if (r_start_pend && !w_empty_c) begin
            w_go        = 1'b1;
            w_state_nxt = PRE;
            w_sh_nxt    = FLAG;
            w_bcnt_nxt  = '0;
            w_pcnt_nxt  = r_pre;
            w_ones_nxt  = '0;
          end
        end
        PRE: begin
          // Rotate so the flag reloads itself for the next opening flag
          w_txen_nxt = 1'b1;
          w_bit      = r_sh[0];
          w_sh_nxt   = {r_sh[0], r_sh[7:1]};
          w_bcnt_nxt = r_bcnt + 4'd1;
          if (r_bcnt == 4'd7) begin
            w_bcnt_nxt = '0;
            if (r_pcnt > 4'd1) w_pcnt_nxt = r_pcnt - 4'd1;
            else               w_bnd      = 1'b1;
          end
        end
        DATA: begin
          w_txen_nxt = 1'b1;
          if (r_ones == 3'd5) begin
            // Stuffed zero; a byte whose tail made the fifth one ends here
            w_bit      = 1'b0;
            w_ones_nxt = '0;
            if (r_bcnt == 4'd8) w_bnd = 1'b1;
          end else begin
            w_bit      = r_sh[0];
            w_sh_nxt   = {1'b0, r_sh[7:1]};
            w_ones_add = r_sh[0] ? (r_ones + 3'd1) : 3'd0;
            w_ones_nxt = w_ones_add;
            if (r_bcnt == 4'd7 && w_ones_add != 3'd5) w_bnd = 1'b1;
            else                                      w_bcnt_nxt = r_bcnt + 4'd1;
          end
        end
        CLOSE: begin
          w_txen_nxt = 1'b1;
          w_bit      = r_sh[0];
          w_sh_nxt   = {r_sh[0], r_sh[7:1]};
          w_bcnt_nxt = r_bcnt + 4'd1;
          if (r_bcnt == 4'd7) begin
            w_state_nxt = IDLE;
            w_bcnt_nxt  = '0;
            w_ones_nxt  = '0;
          end
        end
        ABORT: begin
          w_txen_nxt = 1'b1;
          w_bit      = 1'b1;
          w_bcnt_nxt = r_bcnt + 4'd1;
          if (r_bcnt == 4'd7) begin
            w_state_nxt = IDLE;
            w_bcnt_nxt  = '0;
            w_ones_nxt  = '0;
            w_flush     = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase

      // Byte boundary: close, fetch next byte (ones count carries), or underrun
      if (w_bnd) begin
        w_bcnt_nxt = '0;
        if (r_state == DATA && r_last) begin
          w_state_nxt = CLOSE;
          w_sh_nxt    = FLAG;
          w_ones_nxt  = '0;
        end else if (!w_empty_c) begin
          w_pop       = 1'b1;
          w_sh_nxt    = w_head.data;
          w_last_nxt  = w_head.last;
          w_state_nxt = DATA;
        end else begin
          w_udr_set   = 1'b1;
          w_state_nxt = ABORT;
        end
      end
    end
  end

  // FSM state and serial datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_bcnt  <= '0;
      r_pcnt  <= '0;
      r_ones  <= '0;
      r_last  <= 1'b0;
      r_txd   <= 1'b1;
      r_txen  <= 1'b0;
    end else if (bitce) begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_ones  <= w_ones_nxt;
      r_last  <= w_last_nxt;
      r_txen  <= w_txen_nxt;
`ifdef NRZI_EN
      // r_txd doubles as the NRZI line level; idle returns it to 1
      if (!w_txen_nxt)  r_txd <= 1'b1;
      else if (!w_bit)  r_txd <= ~r_txd;
`else
      r_txd <= w_bit;
`endif
    end
  end

  // Register interface: read data, sticky status, start request, preamble count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_ovf        <= 1'b0;
      r_udr        <= 1'b0;
      r_start_pend <= 1'b0;
      r_pre        <= 4'(PRE_DEF);
    end else begin
      r_dout <= w_rd_stat ? w_status : '0;
      if (w_ctrl && din[1]) begin
        r_ovf <= 1'b0;
        r_udr <= 1'b0;
      end
      if (w_push && w_full_c) r_ovf <= 1'b1;
      if (w_udr_set)          r_udr <= 1'b1;
      if (w_ctrl) r_pre <= (din[7:4] != 4'd0) ? din[7:4] : 4'(PRE_DEF);
      if (w_go)                                r_start_pend <= 1'b0;
      else if (w_ctrl && din[0] && !w_busy)    r_start_pend <= 1'b1;
    end
  end

  assign dout = r_dout;
  assign txd  = r_txd;
  assign txen = r_txen;

endmodule

// File: tb/tb_ax25_hdlc_tx.sv
// tb_ax25_hdlc_tx: scoreboard bench for ax25_hdlc_tx.
//   Expected line bits are generated by a bit-stuffing model and queued
//   when a frame is written; the monitor pops one per keyed bit slot.
`timescale 1ns/1ps
module tb_ax25_hdlc_tx;
  import ax25_pkg::*;

`ifdef NRZI_EN
  localparam bit NRZI = 1'b1;
`else
  localparam bit NRZI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iocs = 1'b0;
  logic [2:0]  ioaddr = '0;
  logic [15:0] din = '0;
  logic        iowr = 1'b0;
  logic        iord = 1'b0;
  logic [15:0] dout;
  logic        bitce = 1'b0;
  logic        txd;
  logic        txen;

  int   n_chk = 0;
  int   n_err = 0;
  bit   q[$];
  int   n_rx = 0;
  int   n_exp = 0;
  bit   mon_en = 1'b0;
  logic prev_lvl = 1'b1;
  logic mon_b;

  ax25_hdlc_tx #(
    .FIFO_DEPTH (16),
    .PRE_DEF    (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .iocs   (iocs),
    .ioaddr (ioaddr),
    .din    (din),
    .iowr   (iowr),
    .iord   (iord),
    .dout   (dout),
    .bitce  (bitce),
    .txd    (txd),
    .txen   (txen)
  );

  always #5 clk = ~clk;

  // One bit slot every four clks
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      bitce = (c % 4 == 3);
      c++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Line monitor: decode one bit per slot, compare keyed bits to the queue
  always @(posedge clk) begin
    if (bitce && mon_en) begin
      #1;
      mon_b    = NRZI ? (txd == prev_lvl) : txd;
      prev_lvl = txd;
      if (txen) begin
        n_rx++;
        if (q.size() > 0) check_eq("txd_bit", 32'(mon_b), 32'(q.pop_front()));
      end
    end
  end

  task automatic push_byte_bits(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      q.push_back(v[i]);
      n_exp++;
    end
  endtask

  // Reference frame: flags, stuffed payload, closing flag or abort
  task automatic exp_frame(input logic [7:0] bytes[$], input int pre, input bit abort_end);
    int ones;
    logic [7:0] v;
    ones = 0;
    for (int p = 0; p < pre; p++) push_byte_bits(8'h7E);
    foreach (bytes[k]) begin
      v = bytes[k];
      for (int i = 0; i < 8; i++) begin
        q.push_back(v[i]);
        n_exp++;
        ones = v[i] ? ones + 1 : 0;
        if (ones == 5) begin
          q.push_back(1'b0);
          n_exp++;
          ones = 0;
        end
      end
    end
    push_byte_bits(abort_end ? 8'hFF : 8'h7E);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    iocs = 1'b1; iowr = 1'b1; ioaddr = a; din = d;
    @(negedge clk);
    iocs = 1'b0; iowr = 1'b0; din = '0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    iocs = 1'b1; iord = 1'b1; ioaddr = a;
    @(negedge clk);
    iocs = 1'b0; iord = 1'b0;
    d = dout;
  endtask

  task automatic check_stat(input string tag, input logic [15:0] exp);
    logic [15:0] v;
    bus_rd(A_STAT, v);
    check_eq(tag, 32'(v), 32'(exp));
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int pre, input bit abort_end);
    exp_frame(bytes, pre, abort_end);
    foreach (bytes[k])
      bus_wr((k == bytes.size() - 1 && !abort_end) ? A_LAST : A_DATA, {8'h00, bytes[k]});
    bus_wr(A_CTRL, {8'h00, 4'(pre), 4'b0001});
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (q.size() != 0 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    check_eq({tag, "_drained"}, 32'(q.size()), 32'd0);
    repeat (40) @(posedge clk);
    check_eq({tag, "_len"}, 32'(n_rx), 32'(n_exp));
    @(negedge clk);
    check_eq({tag, "_txen_off"}, 32'(txen), 32'd0);
    check_eq({tag, "_txd_idle"}, 32'(txd), 32'd1);
    q.delete();
    n_rx  = 0;
    n_exp = 0;
  endtask

  initial begin
    logic [7:0] bq[$];
    int k;

    // Reset state
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_txd", 32'(txd), 32'd1);
    check_eq("rst_txen", 32'(txen), 32'd0);
    rst = 1'b0;
    check_stat("rst_status", 16'h0000);
    prev_lvl = 1'b1;
    mon_en   = 1'b1;

    // Single 0x7E data byte, one opening flag
    bq = '{8'h7E};
    send_frame(bq, 1, 1'b0);
    wait_done("f7e");
    check_stat("f7e_status", 16'h0000);

    // Ones carried across a byte boundary
    bq = '{8'hFF, 8'h01};
    send_frame(bq, 1, 1'b0);
    wait_done("fff01");

    // Random frames with varied preamble counts
    for (int f = 0; f < 3; f++) begin
      bq.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) bq.push_back(8'($urandom));
      send_frame(bq, int'($urandom_range(1, 3)), 1'b0);
      wait_done("rand");
    end

    // Underrun: one non-last byte only
    bq = '{8'h55};
    send_frame(bq, 1, 1'b1);
    wait_done("udr");
    check_stat("udr_status", 16'h0020);
    bus_wr(A_CTRL, 16'h0002);
    check_stat("udr_cleared", 16'h0000);

    // Overflow: 17 pushes into 16 entries, 17th dropped
    bq.delete();
    for (int i = 0; i < 17; i++) begin
      bq.push_back(8'($urandom));
      bus_wr(A_DATA, {8'h00, bq[i]});
    end
    check_stat("ovf_status", 16'h0050);
    bus_wr(A_CTRL, 16'h0002);
    check_stat("ovf_cleared", 16'h0010);
    void'(bq.pop_back());
    exp_frame(bq, 1, 1'b1);
    bus_wr(A_CTRL, 16'h0011);
    wait_done("ovf_drain");
    check_stat("ovf_drain_status", 16'h0020);
    bus_wr(A_CTRL, 16'h0002);

    // Start with an empty FIFO is held until data arrives
    bus_wr(A_CTRL, 16'h0011);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_eq("pend_txen", 32'(txen), 32'd0);
    check_stat("pend_status", 16'h0000);
    bq = '{8'hA5};
    exp_frame(bq, 1, 1'b0);
    bus_wr(A_LAST, 16'h00A5);
    wait_done("pend");

    // Reset in the middle of the payload
    bq = '{8'h3C, 8'hF0, 8'h0F, 8'hAA};
    send_frame(bq, 1, 1'b0);
    k = 0;
    while (n_rx < 14 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    check_eq("mid_reached", 32'(n_rx >= 14), 32'd1);
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_txd", 32'(txd), 32'd1);
    check_eq("midrst_txen", 32'(txen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    n_rx     = 0;
    n_exp    = 0;
    prev_lvl = 1'b1;
    mon_en   = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_eq("postrst_txen", 32'(txen), 32'd0);
    check_eq("postrst_rx", 32'(n_rx), 32'd0);
    check_stat("postrst_status", 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
